// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl: sequences conversion of a two's-complement sample into a small
// float (sign, EXP_W-bit exponent, SIG_W-bit significand). One conversion in flight,
// valid/ready on both sides. Define FP_CTRL_FAST_NORM_EN to normalize in a single
// cycle with a leading-one priority encoder instead of one shift per cycle.
module fp_convert_ctrl #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat
);

  localparam int unsigned MagW = IN_W - 1;
  localparam logic [EXP_W-1:0] ExpMax = '1;
  localparam logic [IN_W-1:0] MostNeg = {1'b1, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e           state_q, state_d;
  logic [MagW-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [SIG_W-1:0] out_sig_q, out_sig_d;
  logic             out_sat_q, out_sat_d;

  logic [MagW-1:0]  neg_mag;
  logic [SIG_W:0]   sig_rnd;

  // Low bits of the negated sample; the upper bit is never needed except for the clamp case.
  assign neg_mag = ~in_data[MagW-1:0] + MagW'(1);

  // Truncated significand plus the round bit, one extra bit to catch overflow.
  assign sig_rnd = {1'b0, mag_q[MagW-1 -: SIG_W]} + {{SIG_W{1'b0}}, mag_q[MagW-1-SIG_W]};

`ifdef FP_CTRL_FAST_NORM_EN
  localparam int ExpMaxInt = (1 << EXP_W) - 1;
  logic [EXP_W-1:0] shift_amt;

  // Leading-one priority encoder; shift saturates at the exponent range (subnormal floor).
  always_comb begin
    shift_amt = ExpMax;
    for (int i = 0; i < int'(MagW); i++) begin
      if (mag_q[i] && ((int'(MagW) - 1 - i) < ExpMaxInt)) begin
        shift_amt = EXP_W'(int'(MagW) - 1 - i);
      end
    end
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_data[IN_W-1];
          exp_d  = ExpMax;
          if (in_data == MostNeg) begin
            mag_d = '1;
            sat_d = 1'b1;
          end else begin
            mag_d = in_data[IN_W-1] ? neg_mag : in_data[MagW-1:0];
            sat_d = 1'b0;
          end
          state_d = StNorm;
        end
      end
      StNorm: begin
`ifdef FP_CTRL_FAST_NORM_EN
        mag_d   = mag_q << shift_amt;
        exp_d   = exp_q - shift_amt;
        state_d = StRound;
`else
        if (exp_q == '0 || mag_q[MagW-1]) begin
          state_d = StRound;
        end else begin
          mag_d = {mag_q[MagW-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
`endif
      end
      StRound: begin
        out_sign_d  = sign_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
        if (sig_rnd[SIG_W]) begin
          if (exp_q != ExpMax) begin
            // Rounded up to 2.0: renormalize to 1.0 at the next exponent.
            out_sig_d = {1'b1, {(SIG_W-1){1'b0}}};
            out_exp_d = exp_q + EXP_W'(1);
            out_sat_d = sat_q;
          end else begin
            out_sig_d = '1;
            out_exp_d = exp_q;
            out_sat_d = 1'b1;
          end
        end else begin
          out_sig_d = sig_rnd[SIG_W-1:0];
          out_exp_d = exp_q;
          out_sat_d = sat_q;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Bench for fp_convert_ctrl: arithmetic reference model plus cycle-by-cycle comparison,
// directed vectors with literal expectations, backpressure, mid-conversion reset and
// randomized traffic.
module tb_fp_convert_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [11:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [2:0] out_exp;
  logic [3:0] out_sig;
  logic       out_sat;

  int n_checks = 0;
  int n_errors = 0;
  bit checking_en = 1'b0;

  fp_convert_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Value-level conversion: exponent from the leading-one position, significand as
  // mag / 2^exp rounded half-up, then overflow handling. n is the normalization shift count.
  function automatic void ref_conv(input logic [11:0] d, output logic s, output int e,
                                   output int sg, output logic st, output int n);
    int v, mag, p;
    v   = $signed(d);
    s   = (v < 0);
    mag = (v < 0) ? -v : v;
    st  = 1'b0;
    if (mag > 2047) begin
      mag = 2047;
      st  = 1'b1;
    end
    if (mag == 0) begin
      e  = 0;
      sg = 0;
      n  = 7;
    end else begin
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      e  = (p > 3) ? p - 3 : 0;
      n  = 7 - e;
      sg = (mag + ((e > 0) ? (1 << (e - 1)) : 0)) >> e;
      if (sg == 16) begin
        if (e < 7) begin
          sg = 8;
          e  = e + 1;
        end else begin
          sg = 15;
          st = 1'b1;
        end
      end
    end
  endfunction

  function automatic int ref_latency(input int n);
`ifdef FP_CTRL_FAST_NORM_EN
    return 2 + 0 * n;
`else
    return n + 2;
`endif
  endfunction

  // Transaction-level model: idle, busy for a fixed latency, then holding a result.
  logic       m_idle, m_valid, m_sign, m_sat;
  logic [2:0] m_exp;
  logic [3:0] m_sig;
  logic       p_sign, p_sat;
  logic [2:0] p_exp;
  logic [3:0] p_sig;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    logic s, st;
    int e, sg, n;
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_sign  <= 1'b0;
      m_exp   <= '0;
      m_sig   <= '0;
      m_sat   <= 1'b0;
      m_cnt   <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        ref_conv(in_data, s, e, sg, st, n);
        p_sign <= s;
        p_exp  <= 3'(e);
        p_sig  <= 4'(sg);
        p_sat  <= st;
        m_cnt  <= ref_latency(n);
        m_idle <= 1'b0;
      end
    end else if (!m_valid) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_sign  <= p_sign;
        m_exp   <= p_exp;
        m_sig   <= p_sig;
        m_sat   <= p_sat;
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (checking_en) begin
      n_checks++;
      if ({in_ready, out_valid, out_sign, out_exp, out_sig, out_sat} !==
          {m_idle, m_valid, m_sign, m_exp, m_sig, m_sat}) begin
        n_errors++;
        $display("FAIL cycle_cmp t=%0t got rdy=%b vld=%b s=%b e=%0d m=%0d sat=%b want rdy=%b vld=%b s=%b e=%0d m=%0d sat=%b",
                 $time, in_ready, out_valid, out_sign, out_exp, out_sig, out_sat,
                 m_idle, m_valid, m_sign, m_exp, m_sig, m_sat);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid (bounded); returns edges elapsed or 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_valid_timeout: got no out_valid want out_valid within 20 cycles");
    end
  endtask

  logic [11:0] vec   [7] = '{12'h200, 12'h07D, 12'h02C, 12'hFFF, 12'h000, 12'h800, 12'h7FF};
  int          w_sign[7] = '{0, 0, 0, 1, 0, 1, 0};
  int          w_exp [7] = '{6, 4, 2, 0, 0, 7, 7};
  int          w_sig [7] = '{8, 8, 11, 1, 0, 15, 15};
  int          w_sat [7] = '{0, 0, 0, 0, 0, 1, 1};
  int          w_n   [7] = '{1, 4, 5, 7, 7, 0, 0};

  initial begin
    logic s, st;
    int e, sg, n, lat;
    bit stayed_low;
    logic [11:0] rd;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Pin the model itself to hand-computed results.
    for (int i = 0; i < 7; i++) begin
      ref_conv(vec[i], s, e, sg, st, n);
      chk($sformatf("model_%03h", vec[i]), {s, 3'(e), 4'(sg), st, 5'(n)},
          {1'(w_sign[i]), 3'(w_exp[i]), 4'(w_sig[i]), 1'(w_sat[i]), 5'(w_n[i])});
    end

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_state", {in_ready, out_valid, out_sign, out_exp, out_sig, out_sat}, 11'b10000000000);
    checking_en = 1'b1;

    // Directed vectors with literal latency and value checks.
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_data   = vec[i];
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid(lat);
`ifdef FP_CTRL_FAST_NORM_EN
      chk($sformatf("latency_%03h", vec[i]), lat, 2);
`else
      chk($sformatf("latency_%03h", vec[i]), lat, w_n[i] + 2);
`endif
      chk($sformatf("result_%03h", vec[i]), {out_sign, out_exp, out_sig, out_sat},
          {1'(w_sign[i]), 3'(w_exp[i]), 4'(w_sig[i]), 1'(w_sat[i])});
      step();
    end

    // Backpressure: 0x123 -> exp 5, sig 9; new sample offered while the result is held.
    in_valid  = 1'b1;
    in_data   = 12'h123;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    in_valid = 1'b1;
    in_data  = 12'h456;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", {in_ready, out_valid, out_sign, out_exp, out_sig, out_sat},
          {1'b0, 1'b1, 1'b0, 3'd5, 4'd9, 1'b0});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    step();
    chk("bp_next_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_result", {out_sign, out_exp, out_sig, out_sat}, {1'b0, 3'd7, 4'd9, 1'b0});
    step();

    // Reset mid-conversion aborts with no result.
    in_valid = 1'b1;
    in_data  = 12'h001;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_state", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #3 rst_n = 1'b1;
    stayed_low = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid !== 1'b0) stayed_low = 1'b0;
    end
    chk("midreset_no_result", stayed_low, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: rd = 12'h000;
        1: rd = 12'h800;
        2: rd = 12'h7FF;
        3: rd = 12'hFFF;
        4: rd = 12'($urandom_range(0, 15));
        default: rd = 12'($urandom());
      endcase
      in_data   = rd;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
